// File: rtl/drive_track_cache.sv
// Single-track disk cache: holds one track in RAM, loads it block-by-block from
// the SD image and writes back only the 512-byte blocks the drive has modified.
module drive_track_cache #(
    parameter int          BLK_BITS = 4,
    parameter int          HT_W     = 7,
    parameter logic [31:0] LBA_BASE = 32'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [31:0]           sd_lba,
    output logic                  sd_rd,
    output logic                  sd_wr,
    input  logic                  sd_ack,
    input  logic [8:0]            sd_buff_addr,
    input  logic [7:0]            sd_buff_dout,
    output logic [7:0]            sd_buff_din,
    input  logic                  sd_buff_wr,
    input  logic                  img_mounted,
    input  logic                  img_readonly,
    input  logic                  flush,
    input  logic                  side,
    input  logic [HT_W-1:0]       half_track,
    input  logic [BLK_BITS+8:0]   buff_addr,
    output logic [7:0]            buff_dout,
    input  logic [7:0]            buff_din,
    input  logic                  buff_we,
    output logic                  busy,
    output logic                  dirty
);

    localparam int AW   = BLK_BITS + 9;
    localparam int NBLK = 1 << BLK_BITS;
    localparam logic [BLK_BITS-1:0] BLK_LAST = {BLK_BITS{1'b1}};
    localparam logic [BLK_BITS-1:0] BLK_ONE  = {{(BLK_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        WR_REQ  = 3'd2,
        WR_WAIT = 3'd3,
        LOAD    = 3'd4,
        RD_REQ  = 3'd5,
        RD_WAIT = 3'd6
    } state_t;

    state_t              state_r, state_s;
    logic [BLK_BITS-1:0] blk_r, blk_s;
    logic [NBLK-1:0]     bitmap_r, bitmap_s;
    logic                cur_side_r, cur_side_s;
    logic [HT_W-1:0]     cur_ht_r, cur_ht_s;
    logic                valid_r, valid_s;
    logic                mounted_r, mounted_s;
    logic                flush_pend_r, flush_pend_s;
    logic                mount_pend_r, mount_pend_s;
    logic [31:0]         lba_off_s;
    logic                track_diff_s, last_blk_s, drv_we_s, sd_we_s;
    logic [AW-1:0]       sd_addr_s;
    logic [7:0]          ram [0:(1<<AW)-1];

    assign track_diff_s = (cur_side_r != side) || (cur_ht_r != half_track);
    assign last_blk_s   = (blk_r == BLK_LAST);
    assign drv_we_s     = buff_we && (state_r == IDLE);
    assign sd_we_s      = sd_buff_wr && (state_r == RD_WAIT);
    assign sd_addr_s    = {blk_r, sd_buff_addr};

    // Next-state logic for the sequencer, dirty bitmap and track bookkeeping
    always_comb begin
        state_s      = state_r;
        blk_s        = blk_r;
        bitmap_s     = bitmap_r;
        cur_side_s   = cur_side_r;
        cur_ht_s     = cur_ht_r;
        valid_s      = valid_r;
        mounted_s    = mounted_r | img_mounted;
        flush_pend_s = flush_pend_r | flush;
        mount_pend_s = mount_pend_r | (img_mounted && (state_r != IDLE));
        lba_off_s    = 32'd0;
        case (state_r)
            IDLE: begin
                flush_pend_s = 1'b0;
                mount_pend_s = 1'b0;
                if (img_mounted || mount_pend_r) begin
                    state_s = LOAD;
                end else if (mounted_r && (flush || flush_pend_r || track_diff_s) &&
                             (|bitmap_r) && !img_readonly) begin
                    state_s = SCAN;
                    blk_s   = {BLK_BITS{1'b0}};
                end else if (mounted_r && (track_diff_s || !valid_r)) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (mount_pend_r) begin
                    state_s = LOAD;
                end else if (bitmap_r[blk_r]) begin
                    state_s = WR_REQ;
                end else if (last_blk_s) begin
                    state_s = track_diff_s ? LOAD : IDLE;
                end else begin
                    blk_s = blk_r + BLK_ONE;
                end
            end
            WR_REQ: begin
                if (sd_ack) begin
                    state_s = WR_WAIT;
                end else begin
                    state_s = WR_REQ;
                end
            end
            WR_WAIT: begin
                if (!sd_ack) begin
                    bitmap_s[blk_r] = 1'b0;
                    if (mount_pend_r) begin
                        state_s = LOAD;
                    end else if (last_blk_s) begin
                        state_s = track_diff_s ? LOAD : IDLE;
                    end else begin
                        blk_s   = blk_r + BLK_ONE;
                        state_s = SCAN;
                    end
                end else begin
                    state_s = WR_WAIT;
                end
            end
            LOAD: begin
                // A new load always discards stale dirty state (remount or read-only track change)
                cur_side_s   = side;
                cur_ht_s     = half_track;
                blk_s        = {BLK_BITS{1'b0}};
                bitmap_s     = {NBLK{1'b0}};
                valid_s      = 1'b0;
                mount_pend_s = 1'b0;
                state_s      = RD_REQ;
            end
            RD_REQ: begin
                if (sd_ack) begin
                    state_s = RD_WAIT;
                end else begin
                    state_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (!sd_ack) begin
                    if (mount_pend_r) begin
                        state_s = LOAD;
                    end else if (last_blk_s) begin
                        valid_s = 1'b1;
                        state_s = IDLE;
                    end else begin
                        blk_s   = blk_r + BLK_ONE;
                        state_s = RD_REQ;
                    end
                end else begin
                    state_s = RD_WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        if (drv_we_s && !img_readonly) begin
            bitmap_s[buff_addr[AW-1:9]] = 1'b1;
        end else begin
            bitmap_s = bitmap_s;
        end
        lba_off_s[BLK_BITS+HT_W:0] = {cur_side_s, cur_ht_s, blk_s};
    end

    // State and registered outputs, derived from next-state so they align with the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            blk_r        <= {BLK_BITS{1'b0}};
            bitmap_r     <= {NBLK{1'b0}};
            cur_side_r   <= 1'b0;
            cur_ht_r     <= {HT_W{1'b0}};
            valid_r      <= 1'b0;
            mounted_r    <= 1'b0;
            flush_pend_r <= 1'b0;
            mount_pend_r <= 1'b0;
            sd_rd        <= 1'b0;
            sd_wr        <= 1'b0;
            busy         <= 1'b0;
            dirty        <= 1'b0;
            sd_lba       <= LBA_BASE;
        end else begin
            state_r      <= state_s;
            blk_r        <= blk_s;
            bitmap_r     <= bitmap_s;
            cur_side_r   <= cur_side_s;
            cur_ht_r     <= cur_ht_s;
            valid_r      <= valid_s;
            mounted_r    <= mounted_s;
            flush_pend_r <= flush_pend_s;
            mount_pend_r <= mount_pend_s;
            sd_rd        <= (state_s == RD_REQ);
            sd_wr        <= (state_s == WR_REQ);
            busy         <= (state_s != IDLE);
            dirty        <= |bitmap_s;
            sd_lba       <= LBA_BASE + lba_off_s;
        end
    end

    // Track RAM write port; drive and SD writes are mutually exclusive by state
    always_ff @(posedge clk) begin
        if (drv_we_s) begin
            ram[buff_addr] <= buff_din;
        end else if (sd_we_s) begin
            ram[sd_addr_s] <= sd_buff_dout;
        end
    end

    // Track RAM read ports with write-through on the writing port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buff_dout   <= 8'd0;
            sd_buff_din <= 8'd0;
        end else begin
            buff_dout   <= drv_we_s ? buff_din : ram[buff_addr];
            sd_buff_din <= sd_we_s ? sd_buff_dout : ram[sd_addr_s];
        end
    end

endmodule
